// File: rtl/jtkunio_vtiming_pkg.sv
// Shared constants for the kunio video timing generator: default raster
// geometry and the range helper used by the elaboration-time checks.
package jtkunio_vtiming_pkg;

   localparam int DEF_HW       = 9;
   localparam int DEF_VW       = 9;
   localparam int DEF_HCNT_END = 383;
   localparam int DEF_HB_START = 260;
   localparam int DEF_HB_END   = 16;
   localparam int DEF_HS_START = 300;
   localparam int DEF_HS_END   = 331;
   localparam int DEF_VCNT_END = 271;
   localparam int DEF_VB_START = 240;
   localparam int DEF_VB_END   = 8;
   localparam int DEF_VS_START = 258;
   localparam int DEF_VS_END   = 261;
   localparam int DEF_IRQ_H    = 0;

   // True when value can be held in an unsigned counter of the given width.
   function automatic bit fits_width(input int unsigned value, input int unsigned width);
      return (64'(value) >> width) == 64'd0;
   endfunction

endpackage

// File: rtl/jtkunio_vtiming_win.sv
// Start/end window flag. The flag sets on the enabled edge where pos equals
// START and clears where pos equals END. Being event driven, it handles
// windows that wrap around the counter end (START > END) without extra logic.
module jtkunio_vtiming_win
   import jtkunio_vtiming_pkg::*;
#(
   parameter int W     = 9,
   parameter int START = 0,
   parameter int END   = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] pos,
   output logic         flag
);

   // Window flag register, updated only on enabled edges.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         flag <= 1'b0;
      end else if (en) begin
         if (pos == W'(START))    flag <= 1'b1;
         else if (pos == W'(END)) flag <= 1'b0;
      end
   end

endmodule

// File: rtl/jtkunio_vtiming.sv
// Video timing generator for the kunio-family video top: counters, blanking,
// sync, render-ahead line, flip-mapped coordinates and a vblank CPU interrupt.
// Optional macro JTKUNIO_VTIMING_RASTER_EN adds a raster-compare interrupt
// source on irq_line; without it irq_line is ignored.
module jtkunio_vtiming
   import jtkunio_vtiming_pkg::*;
#(
   parameter int HW       = DEF_HW,
   parameter int VW       = DEF_VW,
   parameter int HCNT_END = DEF_HCNT_END,
   parameter int HB_START = DEF_HB_START,
   parameter int HB_END   = DEF_HB_END,
   parameter int HS_START = DEF_HS_START,
   parameter int HS_END   = DEF_HS_END,
   parameter int VCNT_END = DEF_VCNT_END,
   parameter int VB_START = DEF_VB_START,
   parameter int VB_END   = DEF_VB_END,
   parameter int VS_START = DEF_VS_START,
   parameter int VS_END   = DEF_VS_END,
   parameter int IRQ_H    = DEF_IRQ_H
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pxl_cen,
   input  logic          flip,
   input  logic          irq_ack,
   input  logic [VW-1:0] irq_line,
   output logic [HW-1:0] hdump,
   output logic [VW-1:0] vdump,
   output logic [VW-1:0] vrender,
   output logic [HW-1:0] hf,
   output logic [VW-1:0] vf,
   output logic          flip_l,
   output logic          Hinit,
   output logic          Vinit,
   output logic          LHBL,
   output logic          LVBL,
   output logic          HS,
   output logic          VS,
   output logic          h8,
   output logic          v8,
   output logic          irq
);

   if (!fits_width(HCNT_END, HW)) begin : g_bad_hcnt
      $error("jtkunio_vtiming: HCNT_END does not fit in HW bits");
   end
   if (!fits_width(VCNT_END, VW)) begin : g_bad_vcnt
      $error("jtkunio_vtiming: VCNT_END does not fit in VW bits");
   end
   if (HB_END >= HB_START) begin : g_bad_hblank
      $error("jtkunio_vtiming: HB_END must be below HB_START");
   end

   logic [HW-1:0] hnext;
   logic [VW-1:0] vnext;
   logic          hwrap, vwrap, irq_set;

   // Next counter values; the window flags look at these so they change on
   // the same edge as the counter value that causes them.
   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      hwrap   = hdump == HW'(HCNT_END);
      vwrap   = vdump == VW'(VCNT_END);
      hnext   = hwrap ? '0 : hdump + 1'b1;
      vnext   = vdump;
      vrender = vwrap ? '0 : vdump + 1'b1;
      if (hwrap) vnext = vwrap ? '0 : vdump + 1'b1;
   end

   // Counters, line/frame strobes and the frame-latched flip.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hdump  <= '0;
         vdump  <= '0;
         Hinit  <= 1'b0;
         Vinit  <= 1'b0;
         flip_l <= 1'b0;
      end else if (pxl_cen) begin
         hdump <= hnext;
         vdump <= vnext;
         Hinit <= hnext == '0;
         Vinit <= hnext == '0 && vnext == '0;
         if (hnext == '0 && vnext == '0) flip_l <= flip;
      end
   end

   // Horizontal windows follow the pixel counter directly.
   jtkunio_vtiming_win #(.W(HW), .START(HB_END), .END(HB_START)) u_lhbl (
      .clk(clk), .rst_n(rst_n), .en(pxl_cen), .pos(hnext), .flag(LHBL));

   jtkunio_vtiming_win #(.W(HW), .START(HS_START), .END(HS_END)) u_hs (
      .clk(clk), .rst_n(rst_n), .en(pxl_cen), .pos(hnext), .flag(HS));

   // LVBL is updated at the start of horizontal blank using the upcoming line,
   // so a line is either fully visible or fully blanked.
   jtkunio_vtiming_win #(.W(VW), .START(VB_END), .END(VB_START)) u_lvbl (
      .clk(clk), .rst_n(rst_n), .en(pxl_cen && hnext == HW'(HB_START)),
      .pos(vrender), .flag(LVBL));

   // VS toggles at the horizontal sync position of its start/end lines.
   jtkunio_vtiming_win #(.W(VW), .START(VS_START), .END(VS_END)) u_vs (
      .clk(clk), .rst_n(rst_n), .en(pxl_cen && hnext == HW'(HS_START)),
      .pos(vdump), .flag(VS));

`ifdef JTKUNIO_VTIMING_RASTER_EN
   logic [VW-1:0] line_l;

   // Raster compare line is captured at each line start; a change therefore
   // applies from the following line on.
   always_ff @(posedge clk) begin
      if (!rst_n)                          line_l <= '0;
      else if (pxl_cen && hnext == '0)     line_l <= irq_line;
   end

   assign irq_set = pxl_cen && hnext == HW'(IRQ_H) &&
                    (vnext == VW'(VB_START) || vnext == line_l);
`else
   logic unused_irq_line;
   assign unused_irq_line = ^irq_line;
   assign irq_set = pxl_cen && hnext == HW'(IRQ_H) && vnext == VW'(VB_START);
`endif

   // Level interrupt: a new event wins over a coincident acknowledge.
   always_ff @(posedge clk) begin
      if (!rst_n)       irq <= 1'b0;
      else if (irq_set) irq <= 1'b1;
      else if (irq_ack) irq <= 1'b0;
   end

   assign hf = hdump ^ {HW{flip_l}};
   assign vf = vdump ^ {VW{flip_l}};
   assign h8 = hdump[3];
   assign v8 = vdump[3] && (LVBL || vdump[2]);

endmodule

// File: tb/tb_jtkunio_vtiming.sv
// Scoreboard bench for jtkunio_vtiming on a reduced 24x14 raster. The stimulus
// process steps a small behavioural model per clock and queues the expected
// output word; the monitor pops one entry after each clock edge and compares.
module tb_jtkunio_vtiming;

   localparam int HW = 5, VW = 4;
   localparam int HE = 23, HBS = 18, HBE = 3, HSS = 19, HSE = 22;
   localparam int VE = 13, VBS = 10, VBE = 2, VSS = 11, VSE = 12, IRQH = 0;
   localparam int FRAME_PIX = (HE + 1) * (VE + 1);

   logic          clk = 1'b0;
   logic          rst_n, pxl_cen, flip, irq_ack;
   logic [VW-1:0] irq_line;
   logic [HW-1:0] hdump, hf;
   logic [VW-1:0] vdump, vrender, vf;
   logic          flip_l, Hinit, Vinit, LHBL, LVBL, HS, VS, h8, v8, irq;

   jtkunio_vtiming #(
      .HW(HW), .VW(VW), .HCNT_END(HE), .HB_START(HBS), .HB_END(HBE),
      .HS_START(HSS), .HS_END(HSE), .VCNT_END(VE), .VB_START(VBS),
      .VB_END(VBE), .VS_START(VSS), .VS_END(VSE), .IRQ_H(IRQH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .flip(flip),
      .irq_ack(irq_ack), .irq_line(irq_line), .hdump(hdump), .vdump(vdump),
      .vrender(vrender), .hf(hf), .vf(vf), .flip_l(flip_l), .Hinit(Hinit),
      .Vinit(Vinit), .LHBL(LHBL), .LVBL(LVBL), .HS(HS), .VS(VS), .h8(h8),
      .v8(v8), .irq(irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          cen;
      bit          rst;
      logic [31:0] exp;
   } rec_t;

   rec_t q[$];
   int   vectors = 0, miscompares = 0;

   // Behavioural model state (values after the most recent edge).
   int mh, mv, mline, mframe;
   bit mfl, mirq, minit;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic bit vis(input int x);
      return x >= VBE && x < VBS;
   endfunction

   function automatic bit vsw(input int x);
      return x >= VSS && x < VSE;
   endfunction

   function automatic logic [31:0] model_vec();
      int vr, vprev, hfm, vfm;
      bit lhbl, lvbl, hs, vs, v8m;
      vr    = (mv == VE) ? 0 : mv + 1;
      vprev = (mv == 0) ? VE : mv - 1;
      hfm   = mfl ? (mh ^ 31) : mh;
      vfm   = mfl ? (mv ^ 15) : mv;
      lhbl  = mh >= HBE && mh < HBS;
      lvbl  = (mh >= HBS) ? vis(vr) : vis(mv);
      hs    = mh >= HSS && mh < HSE;
      vs    = (mh >= HSS) ? vsw(mv) : vsw(vprev);
      v8m   = bit'(mv >> 3) && (lvbl || bit'(mv >> 2));
      return {HW'(mh), HW'(hfm), VW'(mv), VW'(vr), VW'(vfm), mfl,
              minit && mh == 0, minit && mh == 0 && mv == 0,
              lhbl, lvbl, hs, vs, bit'(mh >> 3), v8m, mirq};
   endfunction

   // Drive one clock's inputs, advance the model past that edge, queue result.
   task automatic tick(input bit rst, input bit cen, input bit ack, input bit fl);
      int   hn, vn;
      bit   set;
      rec_t r;
      @(negedge clk);
      rst_n   = rst;
      pxl_cen = cen;
      irq_ack = ack;
      flip    = fl;
      if (!rst) begin
         mh = 0; mv = 0; mline = 0; mfl = 0; mirq = 0; minit = 0;
      end else begin
         set = 0;
         if (cen) begin
            hn  = (mh == HE) ? 0 : mh + 1;
            vn  = (mh == HE) ? ((mv == VE) ? 0 : mv + 1) : mv;
            set = hn == IRQH && vn == VBS;
`ifdef JTKUNIO_VTIMING_RASTER_EN
            if (hn == IRQH && vn == mline) set = 1;
`endif
            if (hn == 0) mline = int'(irq_line);
            if (hn == 0 && vn == 0) begin
               mfl = fl;
               mframe++;
            end
            mh = hn; mv = vn; minit = 1;
         end
         if (set)      mirq = 1;
         else if (ack) mirq = 0;
      end
      r.cen = cen;
      r.rst = rst;
      r.exp = model_vec();
      q.push_back(r);
   endtask

   // Monitor: compare every queued expectation after its edge, plus a few
   // hand-computed spot checks on frame length, flip mapping and reset.
   initial begin
      rec_t        r;
      logic [31:0] act;
      int          pix = 0;
      bit          seen_vinit = 0, prev_vinit = 0, hf0_done = 0, hf1_done = 0, vf_done = 0;
      forever begin
         @(posedge clk);
         #2;
         if (q.size() > 0) begin
            r   = q.pop_front();
            act = {hdump, hf, vdump, vrender, vf, flip_l, Hinit, Vinit,
                   LHBL, LVBL, HS, VS, h8, v8, irq};
            check($sformatf("scoreboard h%0d v%0d", hdump, vdump), act, r.exp);
            if (!r.rst) begin
               check("reset_irq", 32'(irq), 32'd0);
               check("reset_vrender", 32'(vrender), 32'd1);
               seen_vinit = 0;
            end else if (r.cen) begin
               pix++;
            end
            if (Vinit && !prev_vinit) begin
               if (seen_vinit) check("frame_len", 32'(pix), 32'(FRAME_PIX));
               seen_vinit = 1;
               pix = 0;
            end
            prev_vinit = Vinit;
            if (!hf0_done && !flip_l && hdump == 16 && vdump > 5) begin
               check("hf_noflip_16", 32'(hf), 32'd16);
               hf0_done = 1;
            end
            if (!hf1_done && flip_l && hdump == 16) begin
               check("hf_flip_16", 32'(hf), 32'd15);
               hf1_done = 1;
            end
            if (!vf_done && flip_l && vdump == 0) begin
               check("vf_flip_0", 32'(vf), 32'd15);
               vf_done = 1;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit rst, cen, ack, fl, rst_done;
      int post, k, n;
      rst_n = 1'b0; pxl_cen = 1'b0; irq_ack = 1'b0; flip = 1'b0; irq_line = 4'd5;
      mframe = 0;
      for (int i = 0; i < 3; i++) tick(1'b0, bit'(i % 2), 1'b0, 1'b0);

      fl = 0; rst_done = 0; post = 0; k = 0;
      while (k < 5000 && post < 120) begin
         cen = (k % 2) == 1;
         rst = 1;
         ack = 0;
         // Flip requested mid-frame 0; must only take effect at frame 1.
         if (mframe == 0 && mv >= 5) fl = 1;
         // Acknowledge while irq is low: no effect.
         if (mframe == 0 && mv == 3 && mh == 5 && !cen) ack = 1;
         // Acknowledge coincident with the vblank set edge: set wins.
         if (mframe == 1 && cen && mh == HE && mv == VBS - 1) ack = 1;
         // Ordinary acknowledge a few pixels after the event.
         if (mirq && mframe < 2 && mh == 6) ack = 1;
         // Single-clock reset mid-frame with irq pending.
         if (!rst_done && mframe == 2 && mv == 11 && mh == 2 && mirq) begin
            rst = 0;
            rst_done = 1;
         end
         if (rst_done) post++;
         tick(rst, cen, ack, fl);
         k++;
      end
      if (!rst_done) begin
         vectors++;
         miscompares++;
         $display("FAIL reset_point: got not-reached expected reached");
      end

      n = 0;
      while (q.size() > 0 && n < 10) begin
         @(posedge clk);
         n++;
      end
      #3;
      if (q.size() > 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
